cache_arbiter: RTL and testbench

Two-master to one-slave Wishbone arbiter that shares the physical-memory port between the instruction cache and the data cache. Each cache's memory-side `wishbone.master` connects to one slave port here; the arbiter's single master port connects to physical memory (or the next cache level). It serializes whole-line transactions, round-robin between the two caches, and keeps saturating per-port grant counters for performance debug.

---
 rtl/cache_arbiter_if.sv | 23 ++
 rtl/cache_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Wishbone bundle shared by the cache memory ports and the physical-memory port.
// Master drives address/data/strobes; slave returns data, ACK and RTY.
interface wishbone;
  logic [11:0]  ADR;
  logic [127:0] DAT_M;
  logic [127:0] DAT_S;
  logic [15:0]  SEL;
  logic         CYC;
  logic         STB;
  logic         WE;
  logic         ACK;
  logic         RTY;

  modport master (
    output ADR, DAT_M, SEL, CYC, STB, WE,
    input  DAT_S, ACK, RTY
  );

  modport slave (
    input  ADR, DAT_M, SEL, CYC, STB, WE,
    output DAT_S, ACK, RTY
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one Wishbone memory port between the I-cache (port 0)
// and D-cache (port 1); whole-line transactions, saturating per-port grant counters.
module cache_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  wishbone.slave           wb_icache,
  wishbone.slave           wb_dcache,
  wishbone.master          wb_mem,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic req0, req1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign req0 = wb_icache.CYC & wb_icache.STB;
  assign req1 = wb_dcache.CYC & wb_dcache.STB;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = prio_q ? GNT1 : GNT0;
        else if (req0)     state_d = GNT0;
        else if (req1)     state_d = GNT1;
      end
      GNT0: begin
        // ACK wins over a same-cycle abort
        if (wb_mem.ACK) begin
          state_d = IDLE;
          prio_d  = 1'b1;
          cnt0_d  = sat_inc(cnt0_q);
        end else if (!req0) begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        if (wb_mem.ACK) begin
          state_d = IDLE;
          prio_d  = 1'b0;
          cnt1_d  = sat_inc(cnt1_q);
        end else if (!req1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  logic         gnt0, gnt1;
  logic [11:0]  mem_adr;
  logic [127:0] mem_dat;
  logic [15:0]  mem_sel;
  logic         mem_cyc, mem_stb, mem_we;

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // Downstream is a pure mux on the registered grant, so IDLE never leaks a request
  always_comb begin
    mem_adr = '0;
    mem_dat = '0;
    mem_sel = '0;
    mem_cyc = 1'b0;
    mem_stb = 1'b0;
    mem_we  = 1'b0;
    if (gnt0) begin
      mem_adr = wb_icache.ADR;
      mem_dat = wb_icache.DAT_M;
      mem_sel = wb_icache.SEL;
      mem_cyc = wb_icache.CYC;
      mem_stb = wb_icache.STB;
      mem_we  = wb_icache.WE;
    end else if (gnt1) begin
      mem_adr = wb_dcache.ADR;
      mem_dat = wb_dcache.DAT_M;
      mem_sel = wb_dcache.SEL;
      mem_cyc = wb_dcache.CYC;
      mem_stb = wb_dcache.STB;
      mem_we  = wb_dcache.WE;
    end
  end

  assign wb_mem.ADR   = mem_adr;
  assign wb_mem.DAT_M = mem_dat;
  assign wb_mem.SEL   = mem_sel;
  assign wb_mem.CYC   = mem_cyc;
  assign wb_mem.STB   = mem_stb;
  assign wb_mem.WE    = mem_we;

  assign wb_icache.DAT_S = gnt0 ? wb_mem.DAT_S : '0;
  assign wb_icache.ACK   = gnt0 & wb_mem.ACK;
  assign wb_icache.RTY   = gnt0 ? (req0 & ~wb_mem.ACK) : req0;

  assign wb_dcache.DAT_S = gnt1 ? wb_mem.DAT_S : '0;
  assign wb_dcache.ACK   = gnt1 & wb_mem.ACK;
  assign wb_dcache.RTY   = gnt1 ? (req1 & ~wb_mem.ACK) : req1;

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: vector table for reset/round-robin, hand sequences
// for read, write, abort, reset-in-grant, ACK-vs-abort and counter saturation.
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wishbone wb_i ();
  wishbone wb_d ();
  wishbone wb_m ();
  wishbone s_i ();
  wishbone s_d ();
  wishbone s_m ();

  logic [15:0] gc0, gc1;
  logic [1:0]  sc0, sc1;

  cache_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_icache(wb_i), .wb_dcache(wb_d), .wb_mem(wb_m),
    .grant_cnt0(gc0), .grant_cnt1(gc1)
  );

  cache_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .wb_icache(s_i), .wb_dcache(s_d), .wb_mem(s_m),
    .grant_cnt0(sc0), .grant_cnt1(sc1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst_n;
    logic        r0;
    logic        r1;
    logic        ack;
    logic        stb;
    logic [11:0] adr;
    logic        a0;
    logic        a1;
    logic        y0;
    logic        y1;
    logic [15:0] c0;
    logic [15:0] c1;
  } vec_t;

  vec_t tbl[13];
  logic [1:0] sat_exp[5];

  localparam logic [127:0] WDATA = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] RDATA = 128'hFEEDFACE_CAFEBABE_DEADBEEF_55AA33CC;

  initial begin
    // rst r0 r1 ack | stb adr a0 a1 y0 y1 c0 c1
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h111, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h111, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 16'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h0A3, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 16'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A3, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h111, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 16'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A3, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd2};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd2};
    sat_exp[0] = 2'd1;
    sat_exp[1] = 2'd2;
    sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3;
    sat_exp[4] = 2'd3;

    wb_i.ADR = 12'h111; wb_i.DAT_M = 128'h1; wb_i.SEL = 16'h000F; wb_i.WE = 1'b0;
    wb_i.CYC = 1'b1;    wb_i.STB = 1'b1;
    wb_d.ADR = 12'h0A3; wb_d.DAT_M = 128'h2; wb_d.SEL = 16'h00F0; wb_d.WE = 1'b0;
    wb_d.CYC = 1'b1;    wb_d.STB = 1'b1;
    wb_m.DAT_S = RDATA; wb_m.ACK = 1'b0; wb_m.RTY = 1'b0;
    s_i.ADR = 12'h044; s_i.DAT_M = '0; s_i.SEL = '0; s_i.WE = 1'b0; s_i.CYC = 1'b0; s_i.STB = 1'b0;
    s_d.ADR = '0; s_d.DAT_M = '0; s_d.SEL = '0; s_d.WE = 1'b0; s_d.CYC = 1'b0; s_d.STB = 1'b0;
    s_m.DAT_S = '0; s_m.ACK = 1'b0; s_m.RTY = 1'b0;

    step();

    // Table: reset with both requesting, then round-robin 0,1,0,1
    for (int k = 0; k < 13; k++) begin
      rst_n    = tbl[k].rst_n;
      wb_i.CYC = tbl[k].r0; wb_i.STB = tbl[k].r0;
      wb_d.CYC = tbl[k].r1; wb_d.STB = tbl[k].r1;
      wb_m.ACK = tbl[k].ack;
      #1;
      chk($sformatf("v%0d mem_stb", k), wb_m.STB, tbl[k].stb);
      chk($sformatf("v%0d mem_cyc", k), wb_m.CYC, tbl[k].stb);
      chk($sformatf("v%0d mem_adr", k), wb_m.ADR, tbl[k].adr);
      chk($sformatf("v%0d ack0", k), wb_i.ACK, tbl[k].a0);
      chk($sformatf("v%0d ack1", k), wb_d.ACK, tbl[k].a1);
      chk($sformatf("v%0d rty0", k), wb_i.RTY, tbl[k].y0);
      chk($sformatf("v%0d rty1", k), wb_d.RTY, tbl[k].y1);
      chk($sformatf("v%0d cnt0", k), gc0, tbl[k].c0);
      chk($sformatf("v%0d cnt1", k), gc1, tbl[k].c1);
      step();
    end
    wb_m.ACK = 1'b0;

    // Single-port D-cache read, memory ACK three cycles after STB
    wb_d.CYC = 1'b1; wb_d.STB = 1'b1; wb_d.WE = 1'b0;
    #1;
    chk("rd idle_no_stb", wb_m.STB, 1'b0);
    step();
    chk("rd stb", wb_m.STB, 1'b1);
    chk("rd adr", wb_m.ADR, 12'h0A3);
    chk("rd we", wb_m.WE, 1'b0);
    step();
    chk("rd wait_ack1", wb_d.ACK, 1'b0);
    step();
    step();
    wb_m.ACK = 1'b1;
    #1;
    chk("rd ack1", wb_d.ACK, 1'b1);
    chk("rd dat1", wb_d.DAT_S, RDATA);
    chk("rd ack0", wb_i.ACK, 1'b0);
    chk("rd dat0", wb_i.DAT_S, 128'h0);
    wb_d.CYC = 1'b0; wb_d.STB = 1'b0;
    step();
    wb_m.ACK = 1'b0;
    #1;
    chk("rd cnt1", gc1, 16'd3);
    chk("rd idle_stb", wb_m.STB, 1'b0);

    // D-cache write pass-through
    wb_d.WE = 1'b1; wb_d.DAT_M = WDATA; wb_d.SEL = 16'hFFFF;
    wb_d.CYC = 1'b1; wb_d.STB = 1'b1;
    step();
    chk("wr dat", wb_m.DAT_M, WDATA);
    chk("wr sel", wb_m.SEL, 16'hFFFF);
    chk("wr we", wb_m.WE, 1'b1);
    wb_m.ACK = 1'b1;
    step();
    wb_m.ACK = 1'b0;
    wb_d.CYC = 1'b0; wb_d.STB = 1'b0; wb_d.WE = 1'b0;
    #1;
    chk("wr idle_we", wb_m.WE, 1'b0);
    chk("wr idle_dat", wb_m.DAT_M, 128'h0);
    chk("wr idle_sel", wb_m.SEL, 16'h0);
    chk("wr cnt1", gc1, 16'd4);

    // Abort by port 0 while port 1 waits
    wb_i.CYC = 1'b1; wb_i.STB = 1'b1;
    wb_d.CYC = 1'b1; wb_d.STB = 1'b1;
    step();
    chk("ab gnt0_adr", wb_m.ADR, 12'h111);
    wb_i.CYC = 1'b0; wb_i.STB = 1'b0;
    #1;
    chk("ab mem_cyc", wb_m.CYC, 1'b0);
    chk("ab rty1", wb_d.RTY, 1'b1);
    step();
    chk("ab idle_stb", wb_m.STB, 1'b0);
    chk("ab cnt0", gc0, 16'd2);
    step();
    chk("ab gnt1_adr", wb_m.ADR, 12'h0A3);
    chk("ab gnt1_stb", wb_m.STB, 1'b1);
    wb_m.ACK = 1'b1;
    step();
    wb_m.ACK = 1'b0;
    wb_d.CYC = 1'b0; wb_d.STB = 1'b0;
    #1;
    chk("ab cnt1", gc1, 16'd5);

    // Reset while granted
    wb_i.CYC = 1'b1; wb_i.STB = 1'b1;
    step();
    chk("rg stb", wb_m.STB, 1'b1);
    rst_n = 1'b0;
    step();
    chk("rg stb_after", wb_m.STB, 1'b0);
    chk("rg cyc_after", wb_m.CYC, 1'b0);
    chk("rg cnt0", gc0, 16'd0);
    chk("rg cnt1", gc1, 16'd0);
    rst_n = 1'b1;
    step();
    chk("rg regrant_adr", wb_m.ADR, 12'h111);

    // Abort and ACK in the same cycle count as ACK
    wb_i.CYC = 1'b0; wb_i.STB = 1'b0;
    wb_m.ACK = 1'b1;
    #1;
    chk("aa ack0", wb_i.ACK, 1'b1);
    step();
    wb_m.ACK = 1'b0;
    wb_i.CYC = 1'b1; wb_i.STB = 1'b1;
    wb_d.CYC = 1'b1; wb_d.STB = 1'b1;
    #1;
    chk("aa cnt0", gc0, 16'd1);
    step();
    chk("aa prio_adr", wb_m.ADR, 12'h0A3);
    wb_i.CYC = 1'b0; wb_i.STB = 1'b0;
    wb_d.CYC = 1'b0; wb_d.STB = 1'b0;
    step();

    // Saturation on the CNT_W=2 instance
    s_i.CYC = 1'b1; s_i.STB = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("sat%0d stb", k), s_m.STB, 1'b1);
      s_m.ACK = 1'b1;
      step();
      s_m.ACK = 1'b0;
      #1;
      chk($sformatf("sat%0d cnt0", k), sc0, sat_exp[k]);
    end
    s_i.CYC = 1'b0; s_i.STB = 1'b0;
    step();
    chk("sat cnt1", sc1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
